// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory address
// and registers the returned word into the IF/ID slot.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   stall_i, flush_i         hazard-unit hold / squash of the IF/ID slot
//   redirect_i, redirect_pc_i  taken branch/jump and its target
//   iaddr_o, idata_i         instruction memory address / returned word
//   ifid_instr_o, ifid_pc_o, ifid_pc4_o  registered instruction, PC, PC+4
//   ifid_valid_o, ifid_fault_o  slot holds a real instruction / fault bubble
//   halted_o                 fetch is halted after a fault
module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [32:0] IMEM_BYTES = 33'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] iaddr_o,
  input  logic [31:0] idata_i,
  output logic [31:0] ifid_instr_o,
  output logic [31:0] ifid_pc_o,
  output logic [31:0] ifid_pc4_o,
  output logic        ifid_valid_o,
  output logic        ifid_fault_o,
  output logic        halted_o
);

  localparam logic RUN  = 1'b0;
  localparam logic HALT = 1'b1;

  logic        state;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic [32:0] limit;
  logic        fault;
  logic        halting;

  // The limit is 33 bits wide so a 4 GiB memory disables the range check.
  assign limit   = IMEM_BYTES - 33'd4;
  assign pc4     = pc + 32'd4;
  assign fault   = (pc[1:0] != 2'b00) | ({1'b0, pc} > limit);
  assign halting = (state == RUN) & fault & ~stall_i
                 & ~redirect_i & ~flush_i;

  assign iaddr_o  = pc;
  assign halted_o = (state == HALT);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (redirect_i) begin
      pc <= redirect_pc_i;
    end else if ((state == HALT) | stall_i | fault) begin
      pc <= pc;
    end else begin
      pc <= pc4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else if (redirect_i) begin
      state <= RUN;
    end else if (halting) begin
      state <= HALT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst | redirect_i | flush_i) begin
      ifid_instr_o <= 32'h0;
      ifid_pc_o    <= 32'h0;
      ifid_pc4_o   <= 32'h0;
      ifid_valid_o <= 1'b0;
      ifid_fault_o <= 1'b0;
    end else if (state == HALT) begin
      ifid_instr_o <= 32'h0;
      ifid_pc_o    <= 32'h0;
      ifid_pc4_o   <= 32'h0;
      ifid_valid_o <= 1'b0;
      ifid_fault_o <= 1'b0;
    end else if (stall_i) begin
      ifid_instr_o <= ifid_instr_o;
      ifid_pc_o    <= ifid_pc_o;
      ifid_pc4_o   <= ifid_pc4_o;
      ifid_valid_o <= ifid_valid_o;
      ifid_fault_o <= ifid_fault_o;
    end else if (fault) begin
      // Fault marker: pulses once, HALT turns the slot into a bubble after.
      ifid_instr_o <= 32'h0;
      ifid_pc_o    <= pc;
      ifid_pc4_o   <= pc4;
      ifid_valid_o <= 1'b0;
      ifid_fault_o <= 1'b1;
    end else begin
      ifid_instr_o <= idata_i;
      ifid_pc_o    <= pc;
      ifid_pc4_o   <= pc4;
      ifid_valid_o <= 1'b1;
      ifid_fault_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: sequential fetch, stall, redirect,
// flush, fault halting, reset during halt and PC wrap-around.
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        redir;
  logic [31:0] redir_pc;
  logic [31:0] iaddr;
  logic [31:0] idata;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic        valid;
  logic        fault;
  logic        halted;

  logic        rst2;
  logic [31:0] iaddr2;
  logic [31:0] idata2;
  logic [31:0] instr2;
  logic [31:0] pc2;
  logic [31:0] pc42;
  logic        valid2;
  logic        fault2;
  logic        halted2;

  int errors;
  int checks;

  // Memory word at address A is {16'hC0DE, A[15:0]}.
  assign idata  = {16'hC0DE, iaddr[15:0]};
  assign idata2 = {16'hC0DE, iaddr2[15:0]};

  if_stage #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_BYTES (33'd1024)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall),
    .flush_i       (flush),
    .redirect_i    (redir),
    .redirect_pc_i (redir_pc),
    .iaddr_o       (iaddr),
    .idata_i       (idata),
    .ifid_instr_o  (instr),
    .ifid_pc_o     (pc),
    .ifid_pc4_o    (pc4),
    .ifid_valid_o  (valid),
    .ifid_fault_o  (fault),
    .halted_o      (halted)
  );

  if_stage #(
    .RESET_PC   (32'hFFFF_FFFC),
    .IMEM_BYTES (33'h1_0000_0000)
  ) dut_wrap (
    .clk           (clk),
    .rst           (rst2),
    .stall_i       (1'b0),
    .flush_i       (1'b0),
    .redirect_i    (1'b0),
    .redirect_pc_i (32'h0),
    .iaddr_o       (iaddr2),
    .idata_i       (idata2),
    .ifid_instr_o  (instr2),
    .ifid_pc_o     (pc2),
    .ifid_pc4_o    (pc42),
    .ifid_valid_o  (valid2),
    .ifid_fault_o  (fault2),
    .halted_o      (halted2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    checks++;
    if (iaddr !== 32'h0) begin
      errors++;
      $display("FAIL reset_iaddr got %h exp %h", iaddr, 32'h0);
    end
    checks++;
    if ({instr, pc, pc4, valid, fault, halted} !== 99'h0) begin
      errors++;
      $display("FAIL reset_ifid got %h/%h/%h v%b f%b h%b exp all 0",
               instr, pc, pc4, valid, fault, halted);
    end
    rst = 1'b0;
  endtask

  task automatic test_sequential();
    logic [31:0] exp_a [4];
    logic [31:0] exp_i [4];
    logic [31:0] exp_p [4];
    exp_a = '{32'd4, 32'd8, 32'd12, 32'd16};
    exp_i = '{32'hC0DE_0000, 32'hC0DE_0004,
              32'hC0DE_0008, 32'hC0DE_000C};
    exp_p = '{32'd4, 32'd8, 32'd12, 32'd16};
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (iaddr !== exp_a[i] || instr !== exp_i[i] ||
          pc4 !== exp_p[i] || valid !== 1'b1) begin
        errors++;
        $display("FAIL seq_%0d got a=%h i=%h pc4=%h v=%b exp a=%h i=%h pc4=%h v=1",
                 i, iaddr, instr, pc4, valid,
                 exp_a[i], exp_i[i], exp_p[i]);
      end
    end
  endtask

  task automatic test_stall();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    step();
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (iaddr !== 32'd8 || instr !== 32'hC0DE_0004 ||
          pc !== 32'd4 || valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold_%0d got a=%h i=%h pc=%h v=%b exp a=8 i=c0de0004 pc=4 v=1",
                 i, iaddr, instr, pc, valid);
      end
    end
    stall = 1'b0;
    step();
    checks++;
    if (iaddr !== 32'd12 || instr !== 32'hC0DE_0008 || pc !== 32'd8) begin
      errors++;
      $display("FAIL stall_resume got a=%h i=%h pc=%h exp a=c i=c0de0008 pc=8",
               iaddr, instr, pc);
    end
  endtask

  task automatic test_redirect();
    redir = 1'b1;
    redir_pc = 32'h40;
    stall = 1'b1;
    step();
    redir = 1'b0;
    stall = 1'b0;
    checks++;
    if (iaddr !== 32'h40 || valid !== 1'b0 || instr !== 32'h0) begin
      errors++;
      $display("FAIL redir_bubble got a=%h v=%b i=%h exp a=40 v=0 i=0",
               iaddr, valid, instr);
    end
    step();
    checks++;
    if (instr !== 32'hC0DE_0040 || pc !== 32'h40 ||
        valid !== 1'b1 || iaddr !== 32'h44) begin
      errors++;
      $display("FAIL redir_target got i=%h pc=%h v=%b a=%h exp i=c0de0040 pc=40 v=1 a=44",
               instr, pc, valid, iaddr);
    end
  endtask

  task automatic test_fault_range();
    redir = 1'b1;
    redir_pc = 32'd1012;
    step();
    redir = 1'b0;
    step();
    step();
    step();
    checks++;
    if (iaddr !== 32'd1024 || instr !== 32'hC0DE_03FC || valid !== 1'b1) begin
      errors++;
      $display("FAIL range_last got a=%h i=%h v=%b exp a=400 i=c0de03fc v=1",
               iaddr, instr, valid);
    end
    step();
    checks++;
    if (fault !== 1'b1 || pc !== 32'd1024 || pc4 !== 32'd1028 ||
        valid !== 1'b0 || halted !== 1'b1 || iaddr !== 32'd1024) begin
      errors++;
      $display("FAIL range_fault got f=%b pc=%h pc4=%h v=%b h=%b a=%h exp f=1 pc=400 pc4=404 v=0 h=1 a=400",
               fault, pc, pc4, valid, halted, iaddr);
    end
    stall = 1'b1;
    step();
    stall = 1'b0;
    checks++;
    if (fault !== 1'b0 || halted !== 1'b1 ||
        iaddr !== 32'd1024 || valid !== 1'b0) begin
      errors++;
      $display("FAIL range_halt got f=%b h=%b a=%h v=%b exp f=0 h=1 a=400 v=0",
               fault, halted, iaddr, valid);
    end
    redir = 1'b1;
    redir_pc = 32'h0;
    step();
    redir = 1'b0;
    checks++;
    if (halted !== 1'b0 || iaddr !== 32'h0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL range_unhalt got h=%b a=%h v=%b exp h=0 a=0 v=0",
               halted, iaddr, valid);
    end
    step();
    checks++;
    if (instr !== 32'hC0DE_0000 || valid !== 1'b1 || iaddr !== 32'd4) begin
      errors++;
      $display("FAIL range_resume got i=%h v=%b a=%h exp i=c0de0000 v=1 a=4",
               instr, valid, iaddr);
    end
  endtask

  task automatic test_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (iaddr !== 32'd8 || valid !== 1'b0 || instr !== 32'h0) begin
      errors++;
      $display("FAIL flush_squash got a=%h v=%b i=%h exp a=8 v=0 i=0",
               iaddr, valid, instr);
    end
    step();
    checks++;
    if (instr !== 32'hC0DE_0008 || pc !== 32'd8 || valid !== 1'b1) begin
      errors++;
      $display("FAIL flush_next got i=%h pc=%h v=%b exp i=c0de0008 pc=8 v=1",
               instr, pc, valid);
    end
    flush = 1'b1;
    stall = 1'b1;
    step();
    flush = 1'b0;
    stall = 1'b0;
    checks++;
    if (iaddr !== 32'd12 || valid !== 1'b0 || instr !== 32'h0) begin
      errors++;
      $display("FAIL flush_stall got a=%h v=%b i=%h exp a=c v=0 i=0",
               iaddr, valid, instr);
    end
    step();
    checks++;
    if (instr !== 32'hC0DE_000C || pc !== 32'd12 || iaddr !== 32'd16) begin
      errors++;
      $display("FAIL flush_stall_next got i=%h pc=%h a=%h exp i=c0de000c pc=c a=10",
               instr, pc, iaddr);
    end
  endtask

  task automatic test_misaligned();
    redir = 1'b1;
    redir_pc = 32'h42;
    step();
    redir = 1'b0;
    checks++;
    if (iaddr !== 32'h42 || halted !== 1'b0) begin
      errors++;
      $display("FAIL mis_redir got a=%h h=%b exp a=42 h=0", iaddr, halted);
    end
    step();
    checks++;
    if (fault !== 1'b1 || valid !== 1'b0 || halted !== 1'b1 ||
        iaddr !== 32'h42 || pc !== 32'h42) begin
      errors++;
      $display("FAIL mis_halt got f=%b v=%b h=%b a=%h pc=%h exp f=1 v=0 h=1 a=42 pc=42",
               fault, valid, halted, iaddr, pc);
    end
  endtask

  task automatic test_reset_in_halt();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (iaddr !== 32'h0 || halted !== 1'b0 ||
        valid !== 1'b0 || fault !== 1'b0) begin
      errors++;
      $display("FAIL halt_rst got a=%h h=%b v=%b f=%b exp a=0 h=0 v=0 f=0",
               iaddr, halted, valid, fault);
    end
    step();
    checks++;
    if (iaddr !== 32'd4 || instr !== 32'hC0DE_0000 || valid !== 1'b1) begin
      errors++;
      $display("FAIL halt_rst_run got a=%h i=%h v=%b exp a=4 i=c0de0000 v=1",
               iaddr, instr, valid);
    end
  endtask

  task automatic test_wrap();
    rst2 = 1'b1;
    step();
    rst2 = 1'b0;
    checks++;
    if (iaddr2 !== 32'hFFFF_FFFC || halted2 !== 1'b0) begin
      errors++;
      $display("FAIL wrap_reset got a=%h h=%b exp a=fffffffc h=0",
               iaddr2, halted2);
    end
    step();
    checks++;
    if (iaddr2 !== 32'h0 || pc2 !== 32'hFFFF_FFFC || pc42 !== 32'h0 ||
        instr2 !== 32'hC0DE_FFFC || valid2 !== 1'b1 || fault2 !== 1'b0) begin
      errors++;
      $display("FAIL wrap_pc got a=%h pc=%h pc4=%h i=%h v=%b f=%b exp a=0 pc=fffffffc pc4=0 i=c0defffc v=1 f=0",
               iaddr2, pc2, pc42, instr2, valid2, fault2);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    rst2 = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    redir = 1'b0;
    redir_pc = 32'h0;
    #2;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_fault_range();
    test_flush();
    test_misaligned();
    test_reset_in_halt();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
